umem_arbiter: RTL

- Arbitrates one single-ported, byte-addressed unified memory (instructions at 128+, data below) between instruction fetch (IF) and load/store (DM).
- Registers the winning request, drives one memory access, and returns read data with a valid pulse.
- Aging counter stops DM traffic from starving fetch.
- Sits between the core's IF/MEM stages and the unified memory; the core stalls while its request is ungranted.

---
 rtl/umem_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/umem_arbiter.sv
// Unified-memory arbiter: IF vs DM, one registered access every two cycles, aging for IF.
// Optional misalignment suppression with `define UMEM_ARB_MISALIGN_CHECK_EN.
module umem_arbiter #(
  parameter int          MAX_WAIT  = 3,
  parameter logic [2:0]  IF_FUNCT3 = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        owner_dm_q, we_q, mis_q, mis_d;
  logic        mem_read_q, mem_write_q;
  logic [2:0]  mem_funct3_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        if_rvalid_q, dm_rvalid_q;
  logic [31:0] if_rdata_q, dm_rdata_q;
  logic        if_gnt_w, dm_gnt_w;
  logic        if_aged;

  assign if_aged  = (MAX_WAIT != 0) && (wait_cnt_q >= 4'(MAX_WAIT));
  assign if_gnt_w = (state_q == IDLE) && if_req && (!dm_req || if_aged);
  assign dm_gnt_w = (state_q == IDLE) && dm_req && !if_gnt_w;

  always_comb begin
    wait_cnt_d = 4'd0;
    if (if_req && !if_gnt_w)
      wait_cnt_d = (wait_cnt_q == 4'hf) ? 4'hf : wait_cnt_q + 4'd1;
  end

`ifdef UMEM_ARB_MISALIGN_CHECK_EN
  always_comb begin
    mis_d = 1'b0;
    if (if_gnt_w)
      mis_d = (if_addr[1:0] != 2'b00);
    else if (dm_gnt_w)
      mis_d = ((dm_funct3[1:0] == 2'b01) && dm_addr[0]) ||
              ((dm_funct3[1:0] == 2'b10) && (dm_addr[1:0] != 2'b00));
  end
`else
  assign mis_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      owner_dm_q   <= 1'b0;
      we_q         <= 1'b0;
      mis_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_funct3_q <= 3'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      if_rdata_q   <= 32'd0;
      dm_rdata_q   <= 32'd0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (if_gnt_w || dm_gnt_w) begin
            owner_dm_q   <= dm_gnt_w;
            we_q         <= dm_gnt_w && dm_we;
            mis_q        <= mis_d;
            mem_addr_q   <= dm_gnt_w ? dm_addr : if_addr;
            mem_funct3_q <= dm_gnt_w ? dm_funct3 : IF_FUNCT3;
            mem_wdata_q  <= dm_gnt_w ? dm_wdata : 32'd0;
            mem_read_q   <= !(dm_gnt_w && dm_we) && !mis_d;
            mem_write_q  <= dm_gnt_w && dm_we && !mis_d;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // Memory read data is combinational; capture it on the closing edge.
          if (owner_dm_q) begin
            dm_rvalid_q <= 1'b1;
            dm_rdata_q  <= (we_q || mis_q) ? 32'd0 : mem_rdata;
          end else begin
            if_rvalid_q <= 1'b1;
            if_rdata_q  <= mis_q ? 32'd0 : mem_rdata;
          end
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UMEM_ARB_MISALIGN_CHECK_EN
  logic dm_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dm_err_q <= 1'b0;
    else if (state_q == ACCESS && owner_dm_q)
      dm_err_q <= mis_q;
  end
  assign dm_err = dm_err_q;
`else
  assign dm_err = 1'b0;
`endif

  assign if_gnt     = if_gnt_w;
  assign dm_gnt     = dm_gnt_w;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rvalid  = dm_rvalid_q;
  assign dm_rdata   = dm_rdata_q;
  // Strobes are masked by rst so an aborted access stops driving memory at once.
  assign mem_read   = mem_read_q  && !rst;
  assign mem_write  = mem_write_q && !rst;
  assign mem_funct3 = mem_funct3_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
